// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V core constants, ResultSrc encodings and the
//               commit-trace entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // Field order here is the bit order used for flat trace vectors (pc in MSBs).
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            we;
  } commit_trace_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Registered single-clock FIFO with simultaneous push/pop when
//               full and a sticky drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == FULL_CNT);
  assign w_pop     = pop_i & ~w_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = push_i & (~w_full | w_pop);
  assign w_drop    = push_i & w_full & ~w_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | w_drop;
    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (w_push_ok && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (!w_push_ok && w_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign valid_o    = ~w_empty;
  assign rdata_o    = w_empty ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = w_full;
  assign overflow_o = overflow_q;

endmodule : sync_fifo

`default_nettype wire

// File: rtl/wb_commit_unit.sv
// ============================================================================
// Module      : wb_commit_unit
// Description : Writeback result select, register-file write qualification,
//               retired-instruction counter and commit-trace FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_unit #(
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         RegWriteW,
  input  logic [1:0]                   ResultSrcW,
  input  logic [XLEN-1:0]              ALUResultW,
  input  logic [XLEN-1:0]              ReadDataW,
  input  logic [XLEN-1:0]              PCPlus4W,
  input  logic [4:0]                   RdW,
  input  logic                         MEMWB_valid,
  output logic [XLEN-1:0]              ResultW,
  output logic                         RegFileWE,
  output logic [4:0]                   RdWB,
  output logic [63:0]                  InstRet,
  output logic                         trace_valid,
  output logic [XLEN-1:0]              trace_pc,
  output logic [4:0]                   trace_rd,
  output logic [XLEN-1:0]              trace_wdata,
  output logic                         trace_we,
  input  logic                         trace_ready,
  output logic                         trace_overflow,
  output logic [$clog2(TRACE_DEPTH):0] trace_count
);

  import riscv_pkg::*;

  // Flat entry: {pc, rd, wdata, we}, same field order as commit_trace_t.
  localparam int TW = 2 * XLEN + 6;

  logic [63:0]     instret_q, instret_d;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_pc;
  logic            w_we;
  logic [TW-1:0]   w_entry;
  logic [TW-1:0]   w_head;
  logic            w_full;

  always_comb begin
    w_result = ALUResultW;
    case (ResultSrcW)
      RESULT_MEM: w_result = ReadDataW;
      RESULT_PC4: w_result = PCPlus4W;
      default:    w_result = ALUResultW;
    endcase
  end

  assign w_we      = RegWriteW & MEMWB_valid & (RdW != 5'd0);
  assign w_pc      = PCPlus4W - XLEN'(4);
  assign w_entry   = {w_pc, RdW, w_result, w_we};

  assign ResultW   = w_result;
  assign RegFileWE = w_we;
  assign RdWB      = RdW;

  always_comb begin
    instret_d = instret_q;
    if (MEMWB_valid) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign InstRet = instret_q;

  sync_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (MEMWB_valid),
    .wdata_i    (w_entry),
    .pop_i      (trace_ready),
    .valid_o    (trace_valid),
    .rdata_o    (w_head),
    .count_o    (trace_count),
    .full_o     (w_full),
    .overflow_o (trace_overflow)
  );

  assign trace_we    = w_head[0];
  assign trace_wdata = w_head[XLEN:1];
  assign trace_rd    = w_head[XLEN+5:XLEN+1];
  assign trace_pc    = w_head[TW-1:XLEN+6];

  logic w_unused;
  assign w_unused = w_full;

endmodule : wb_commit_unit

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
// ============================================================================
// Module      : tb_wb_commit_unit
// Description : Directed self-checking bench for wb_commit_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_commit_unit;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;
  logic        MEMWB_valid;
  logic [31:0] ResultW;
  logic        RegFileWE;
  logic [4:0]  RdWB;
  logic [63:0] InstRet;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_wdata;
  logic        trace_we;
  logic        trace_ready;
  logic        trace_overflow;
  logic [2:0]  trace_count;

  int n_pass;
  int n_total;

  wb_commit_unit #(.XLEN(32), .TRACE_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .RegWriteW      (RegWriteW),
    .ResultSrcW     (ResultSrcW),
    .ALUResultW     (ALUResultW),
    .ReadDataW      (ReadDataW),
    .PCPlus4W       (PCPlus4W),
    .RdW            (RdW),
    .MEMWB_valid    (MEMWB_valid),
    .ResultW        (ResultW),
    .RegFileWE      (RegFileWE),
    .RdWB           (RdWB),
    .InstRet        (InstRet),
    .trace_valid    (trace_valid),
    .trace_pc       (trace_pc),
    .trace_rd       (trace_rd),
    .trace_wdata    (trace_wdata),
    .trace_we       (trace_we),
    .trace_ready    (trace_ready),
    .trace_overflow (trace_overflow),
    .trace_count    (trace_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MEMWB_valid = 1'b0;
    RegWriteW   = 1'b0;
    ResultSrcW  = 2'b00;
    ALUResultW  = '0;
    ReadDataW   = '0;
    PCPlus4W    = '0;
    RdW         = '0;
  endtask

  task automatic drive_retire(input logic [31:0] pc4, input logic [4:0] rd, input logic [31:0] alu);
    MEMWB_valid = 1'b1;
    RegWriteW   = 1'b1;
    ResultSrcW  = 2'b00;
    ALUResultW  = alu;
    PCPlus4W    = pc4;
    RdW         = rd;
  endtask

  task automatic do_reset();
    idle();
    trace_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (InstRet !== 64'd0) $display("FAIL reset_instret: got %0d exp 0", InstRet); else n_pass++;
    n_total++; if (trace_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", trace_valid); else n_pass++;
    n_total++; if (trace_count !== 3'd0) $display("FAIL reset_count: got %0d exp 0", trace_count); else n_pass++;
    n_total++; if (trace_overflow !== 1'b0) $display("FAIL reset_overflow: got %b exp 0", trace_overflow); else n_pass++;
    n_total++; if ({trace_pc, trace_rd, trace_wdata, trace_we} !== 70'd0) $display("FAIL reset_trace_data: got pc=%h wdata=%h exp 0", trace_pc, trace_wdata); else n_pass++;
  endtask

  task automatic test_result_mux();
    idle();
    ALUResultW = 32'h1111_2222; ReadDataW = 32'h3333_4444; PCPlus4W = 32'h5555_6668;
    ResultSrcW = 2'b00; #1;
    n_total++; if (ResultW !== 32'h1111_2222) $display("FAIL mux_alu: got %h exp 11112222", ResultW); else n_pass++;
    ResultSrcW = 2'b01; #1;
    n_total++; if (ResultW !== 32'h3333_4444) $display("FAIL mux_mem: got %h exp 33334444", ResultW); else n_pass++;
    ResultSrcW = 2'b10; #1;
    n_total++; if (ResultW !== 32'h5555_6668) $display("FAIL mux_pc4: got %h exp 55556668", ResultW); else n_pass++;
    ResultSrcW = 2'b11; #1;
    n_total++; if (ResultW !== 32'h1111_2222) $display("FAIL mux_11: got %h exp 11112222", ResultW); else n_pass++;
    RdW = 5'd7; #1;
    n_total++; if (RdWB !== 5'd7) $display("FAIL rdwb: got %0d exp 7", RdWB); else n_pass++;
    // Qualified write enable with a valid nonzero destination; cleared before the edge.
    MEMWB_valid = 1'b1; RegWriteW = 1'b1; RdW = 5'd5; #1;
    n_total++; if (RegFileWE !== 1'b1) $display("FAIL we_valid: got %b exp 1", RegFileWE); else n_pass++;
    MEMWB_valid = 1'b0; #1;
    n_total++; if (RegFileWE !== 1'b0) $display("FAIL we_invalid: got %b exp 0", RegFileWE); else n_pass++;
    tick();
    n_total++; if (InstRet !== 64'd0) $display("FAIL invalid_no_retire: got %0d exp 0", InstRet); else n_pass++;
    n_total++; if (trace_count !== 3'd0) $display("FAIL invalid_no_push: got %0d exp 0", trace_count); else n_pass++;
  endtask

  task automatic test_retire_seq();
    do_reset();
    drive_retire(32'h104, 5'd1, 32'hA0);
    tick();
    n_total++; if (trace_valid !== 1'b1) $display("FAIL first_push_valid: got %b exp 1", trace_valid); else n_pass++;
    n_total++; if (InstRet !== 64'd1) $display("FAIL first_instret: got %0d exp 1", InstRet); else n_pass++;
    drive_retire(32'h108, 5'd2, 32'hA1);
    tick();
    drive_retire(32'h10C, 5'd3, 32'hA2);
    tick();
    idle();
    tick();
    n_total++; if (InstRet !== 64'd3) $display("FAIL seq_instret: got %0d exp 3", InstRet); else n_pass++;
    n_total++; if (trace_count !== 3'd3) $display("FAIL seq_count: got %0d exp 3", trace_count); else n_pass++;
    n_total++; if (trace_pc !== 32'h100) $display("FAIL seq_head_pc: got %h exp 00000100", trace_pc); else n_pass++;
    n_total++; if (trace_rd !== 5'd1 || trace_wdata !== 32'hA0 || trace_we !== 1'b1)
      $display("FAIL seq_head_fields: got rd=%0d wdata=%h we=%b exp rd=1 wdata=000000a0 we=1", trace_rd, trace_wdata, trace_we); else n_pass++;
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    n_total++; if (trace_pc !== 32'h104 || trace_count !== 3'd2) $display("FAIL seq_pop: got pc=%h count=%0d exp pc=00000104 count=2", trace_pc, trace_count); else n_pass++;
  endtask

  task automatic test_x0_write();
    do_reset();
    MEMWB_valid = 1'b1; RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b01;
    ReadDataW = 32'hDEADBEEF; ALUResultW = 32'h0; PCPlus4W = 32'h200;
    #1;
    n_total++; if (RegFileWE !== 1'b0) $display("FAIL x0_we: got %b exp 0", RegFileWE); else n_pass++;
    n_total++; if (ResultW !== 32'hDEADBEEF) $display("FAIL x0_result: got %h exp deadbeef", ResultW); else n_pass++;
    tick();
    idle();
    n_total++; if (InstRet !== 64'd1) $display("FAIL x0_instret: got %0d exp 1", InstRet); else n_pass++;
    n_total++; if (trace_we !== 1'b0 || trace_wdata !== 32'hDEADBEEF || trace_pc !== 32'h1FC || trace_rd !== 5'd0)
      $display("FAIL x0_trace: got we=%b wdata=%h pc=%h rd=%0d exp we=0 wdata=deadbeef pc=000001fc rd=0", trace_we, trace_wdata, trace_pc, trace_rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_retire(32'h304, 5'd4, 32'h1);
    tick();
    drive_retire(32'h308, 5'd4, 32'h2);
    trace_ready = 1'b1;
    tick();
    n_total++; if (trace_count !== 3'd1 || trace_pc !== 32'h304) $display("FAIL b2b_first: got count=%0d pc=%h exp count=1 pc=00000304", trace_count, trace_pc); else n_pass++;
    drive_retire(32'h30C, 5'd4, 32'h3);
    tick();
    n_total++; if (trace_count !== 3'd1 || trace_pc !== 32'h308) $display("FAIL b2b_second: got count=%0d pc=%h exp count=1 pc=00000308", trace_count, trace_pc); else n_pass++;
    idle();
    tick();
    trace_ready = 1'b0;
    n_total++; if (trace_count !== 3'd0 || trace_valid !== 1'b0) $display("FAIL b2b_drain: got count=%0d valid=%b exp count=0 valid=0", trace_count, trace_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_retire(32'h1004 + 32'(4 * i), 5'd9, 32'(i));
      tick();
      if (i == 3) begin
        n_total++; if (trace_overflow !== 1'b0 || trace_count !== 3'd4) $display("FAIL ovf_at_full: got ovf=%b count=%0d exp ovf=0 count=4", trace_overflow, trace_count); else n_pass++;
      end
    end
    idle();
    n_total++; if (trace_count !== 3'd4) $display("FAIL ovf_count: got %0d exp 4", trace_count); else n_pass++;
    n_total++; if (trace_overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", trace_overflow); else n_pass++;
    n_total++; if (InstRet !== 64'd5) $display("FAIL ovf_instret: got %0d exp 5", InstRet); else n_pass++;
    n_total++; if (trace_pc !== 32'h1000) $display("FAIL ovf_head: got %h exp 00001000", trace_pc); else n_pass++;
    tick();
    n_total++; if (trace_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", trace_overflow); else n_pass++;

    // Full FIFO with a pop in the same cycle as the fifth push.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_retire(32'h2004 + 32'(4 * i), 5'd10, 32'h2000 + 32'(4 * i));
      trace_ready = (i == 4);
      tick();
    end
    idle();
    trace_ready = 1'b0;
    n_total++; if (trace_overflow !== 1'b0 || trace_count !== 3'd4) $display("FAIL fullpop: got ovf=%b count=%0d exp ovf=0 count=4", trace_overflow, trace_count); else n_pass++;
    n_total++; if (InstRet !== 64'd5) $display("FAIL fullpop_instret: got %0d exp 5", InstRet); else n_pass++;
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (trace_pc !== 32'h2004 + 32'(4 * i) || trace_wdata !== 32'h2004 + 32'(4 * i))
        $display("FAIL drain_order_%0d: got pc=%h wdata=%h exp %h", i, trace_pc, trace_wdata, 32'h2004 + 32'(4 * i)); else n_pass++;
      tick();
    end
    n_total++; if (trace_count !== 3'd0 || trace_valid !== 1'b0) $display("FAIL drain_empty: got count=%0d valid=%b exp 0 0", trace_count, trace_valid); else n_pass++;
    tick();
    n_total++; if (trace_count !== 3'd0 || trace_valid !== 1'b0) $display("FAIL ready_empty: got count=%0d valid=%b exp 0 0", trace_count, trace_valid); else n_pass++;
    trace_ready = 1'b0;
  endtask

  task automatic test_instret_wrap();
    do_reset();
    drive_retire(32'h404, 5'd1, 32'h0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    n_total++; if (InstRet !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_preload: got %h exp ffffffffffffffff", InstRet); else n_pass++;
    tick();
    idle();
    n_total++; if (InstRet !== 64'd0) $display("FAIL wrap_zero: got %h exp 0", InstRet); else n_pass++;
    n_total++; if (trace_count !== 3'd1 || trace_pc !== 32'h400) $display("FAIL wrap_trace: got count=%0d pc=%h exp 1 00000400", trace_count, trace_pc); else n_pass++;
  endtask

  task automatic test_reset_precedence();
    do_reset();
    drive_retire(32'h504, 5'd2, 32'h5);
    tick();
    drive_retire(32'h508, 5'd2, 32'h6);
    tick();
    n_total++; if (trace_count !== 3'd2) $display("FAIL pre_rst_count: got %0d exp 2", trace_count); else n_pass++;
    drive_retire(32'h50C, 5'd2, 32'h7);
    trace_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    trace_ready = 1'b0;
    n_total++; if (InstRet !== 64'd0) $display("FAIL rstp_instret: got %0d exp 0", InstRet); else n_pass++;
    n_total++; if (trace_valid !== 1'b0 || trace_count !== 3'd0) $display("FAIL rstp_fifo: got valid=%b count=%0d exp 0 0", trace_valid, trace_count); else n_pass++;
    n_total++; if (trace_overflow !== 1'b0) $display("FAIL rstp_overflow: got %b exp 0", trace_overflow); else n_pass++;
    n_total++; if (trace_pc !== 32'd0 || trace_wdata !== 32'd0) $display("FAIL rstp_data: got pc=%h wdata=%h exp 0", trace_pc, trace_wdata); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    trace_ready = 1'b0;
    idle();
    test_reset();
    test_result_mux();
    test_retire_seq();
    test_x0_write();
    test_back_to_back();
    test_overflow();
    test_instret_wrap();
    test_reset_precedence();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_wb_commit_unit

`default_nettype wire

// File: doc/wb_commit_unit.md
WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN, data width.
REQ-002 SHALL have parameter TRACE_DEPTH, default 4, commit-trace FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have inputs RegWriteW 1, ResultSrcW 2, ALUResultW XLEN, ReadDataW XLEN, PCPlus4W XLEN, RdW 5, MEMWB_valid 1; these are the WB-side outputs of the MEM/WB stage register.
REQ-006 SHALL have output ResultW  XLEN  selected writeback data.
REQ-007 SHALL have output RegFileWE  1  qualified register-file write enable.
REQ-008 SHALL have output RdWB  5  register-file write address (equal to RdW).
REQ-009 SHALL have output InstRet  64  retired-instruction count.
REQ-010 SHALL have outputs trace_valid 1, trace_pc XLEN, trace_rd 5, trace_wdata XLEN, trace_we 1; these form the commit-trace head entry.
REQ-011 SHALL have input trace_ready  1  consumer accepts the head entry.
REQ-012 SHALL have output trace_overflow  1  sticky flag; set when a commit was dropped.
REQ-013 SHALL have output trace_count  $clog2(TRACE_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 ResultW SHALL be combinational, same cycle: ResultSrcW 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> ALUResultW.
REQ-015 RegFileWE SHALL equal RegWriteW & MEMWB_valid & (RdW != 0), combinationally.
REQ-016 A retire event SHALL be any cycle with MEMWB_valid=1, regardless of RegWriteW.
REQ-017 InstRet SHALL increment by 1 on the edge that ends each retire cycle, so it is visible one cycle later, and SHALL wrap from 2^64-1 to 0.
REQ-018 Each retire SHALL push the entry {pc = PCPlus4W - 4 (mod 2^XLEN), rd = RdW, wdata = ResultW, we = RegFileWE} into the trace FIFO.
REQ-019 The FIFO SHALL be registered. An entry pushed into an empty FIFO SHALL appear on the trace outputs with trace_valid=1 on the next cycle.
REQ-020 A pop SHALL occur on a cycle with trace_valid & trace_ready. trace outputs SHALL be stable while trace_valid=1 and trace_ready=0.
REQ-021 A push while the FIFO is full SHALL be accepted only if a pop occurs in the same cycle; otherwise the entry SHALL be dropped and trace_overflow set.
REQ-022 A push and a pop in the same cycle SHALL leave trace_count unchanged. Entries SHALL remain in FIFO order and none SHALL be lost.
REQ-023 trace_overflow SHALL stay set until rst. A drop SHALL NOT inhibit the InstRet increment or RegFileWE.
REQ-024 trace_ready=1 while the FIFO is empty SHALL have no effect.
REQ-025 The FIFO pointers SHALL wrap modulo TRACE_DEPTH.

Reset
REQ-026 On rst, the following SHALL reset to 0 on the next edge: InstRet, FIFO pointers, trace_count, trace_valid, trace_overflow.
REQ-027 rst SHALL take precedence over a simultaneous retire or pop; that cycle's retire SHALL be neither counted nor traced.
REQ-028 The trace data outputs SHALL read as 0 while trace_valid=0 after reset.

Structure
REQ-029 riscv_pkg SHALL hold the ResultSrc encodings (RESULT_ALU, RESULT_MEM, RESULT_PC4) and a packed commit_trace_t struct {pc, rd, wdata, we}.
REQ-030 The FIFO SHALL be one sub-module, sync_fifo, parameterized by WIDTH and DEPTH, with synchronous active-high reset.

Verification
REQ-031 Reset, then 3 consecutive retires with PCPlus4W = 0x104, 0x108, 0x10C and trace_ready=0 -> InstRet=3; trace_count=3; head trace_pc=0x100.
REQ-032 RdW=0, RegWriteW=1, MEMWB_valid=1, ResultSrcW=01, ReadDataW=0xDEADBEEF -> RegFileWE=0; ResultW=0xDEADBEEF; trace entry we=0; InstRet increments.
REQ-033 MEMWB_valid=0 with RegWriteW=1, RdW=5 -> RegFileWE=0; no push; InstRet unchanged.
REQ-034 TRACE_DEPTH=4, 5 retires with trace_ready=0 -> trace_count=4; trace_overflow=1; InstRet=5. Repeat the full-FIFO case with trace_ready=1 during the 5th retire -> no overflow; count stays 4.
REQ-035 Preload InstRet path to 0xFFFF_FFFF_FFFF_FFFF (force or long run), then 1 retire -> InstRet=0.
REQ-036 Assert rst in the same cycle as a retire and a pop with 2 entries queued -> next cycle InstRet=0, trace_valid=0, trace_count=0, trace_overflow=0.
